// File: rtl/cache_defs_pkg.sv
// Shared definitions for the instruction-side memory arbiter: state/grant
// encodings and default geometry.
package cache_defs;

  localparam int unsigned IMEM_ADDR_W     = 32;
  localparam int unsigned IMEM_BEAT_W     = 32;
  localparam int unsigned IMEM_LINE_BEATS = 4;

  localparam int unsigned LINE_W        = IMEM_LINE_BEATS * IMEM_BEAT_W;
  localparam int unsigned BEAT_OFFSET_W = $clog2(IMEM_BEAT_W / 8);

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_IC_BUSY,
    ARB_PTW_BUSY,
    ARB_DRAIN
  } type_imem_arb_state_e;

  typedef enum logic {
    ARB_GRANT_IC,
    ARB_GRANT_PTW
  } type_imem_arb_grant_e;

endpackage

// File: rtl/imem_line_assembler.sv
// Refill line assembly: beat counter, per-slot capture and a final-beat bypass
// so the completed line is presented in the same cycle as the last bus ack.
module imem_line_assembler
  import cache_defs::*;
#(
  parameter int unsigned BEAT_W     = IMEM_BEAT_W,
  parameter int unsigned LINE_BEATS = IMEM_LINE_BEATS
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clr_i,
  input  logic                         beat_we_i,
  input  logic                         commit_i,
  input  logic [BEAT_W-1:0]            rdata_i,
  output logic                         last_beat_o,
  output logic [LINE_BEATS*BEAT_W-1:0] line_o
);

  localparam int unsigned CNT_W = $clog2(LINE_BEATS);
  localparam int unsigned BUF_W = (LINE_BEATS - 1) * BEAT_W;
  localparam int unsigned LW    = LINE_BEATS * BEAT_W;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BUF_W-1:0] buf_q, buf_d;
  logic [LW-1:0]    line_q, line_d;
  logic [LW-1:0]    full_line;

  // The last slot is never stored: it is taken straight from the bus.
  assign full_line   = {rdata_i, buf_q};
  assign last_beat_o = (cnt_q == CNT_W'(LINE_BEATS - 1));
  assign line_o      = commit_i ? full_line : line_q;

  always_comb begin
    cnt_d  = cnt_q;
    buf_d  = buf_q;
    line_d = line_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (beat_we_i) begin
      cnt_d = cnt_q + CNT_W'(1);
      for (int unsigned i = 0; i < LINE_BEATS - 1; i++) begin
        if (cnt_q == CNT_W'(i)) begin
          buf_d[i*BEAT_W +: BEAT_W] = rdata_i;
        end
      end
    end
    if (commit_i) begin
      line_d = full_line;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      buf_q  <= '0;
      line_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      buf_q  <= buf_d;
      line_q <= line_d;
    end
  end

endmodule

// File: rtl/imem_arbiter.sv
// Shares the instruction-side memory port between icache refills (multi-beat)
// and the MMU page-table walker (single beat) with round-robin arbitration.
module imem_arbiter
  import cache_defs::*;
#(
  parameter int unsigned ADDR_W     = IMEM_ADDR_W,
  parameter int unsigned BEAT_W     = IMEM_BEAT_W,
  parameter int unsigned LINE_BEATS = IMEM_LINE_BEATS
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         ic_req_i,
  input  logic [ADDR_W-1:0]            ic_addr_i,
  input  logic                         ic_kill_i,
  output logic                         ic_ack_o,
  output logic [LINE_BEATS*BEAT_W-1:0] ic_line_o,
  input  logic                         ptw_req_i,
  input  logic [ADDR_W-1:0]            ptw_addr_i,
  output logic                         ptw_ack_o,
  output logic [BEAT_W-1:0]            ptw_rdata_o,
  output logic                         mem_req_o,
  output logic [ADDR_W-1:0]            mem_addr_o,
  input  logic                         mem_ack_i,
  input  logic [BEAT_W-1:0]            mem_rdata_i
);

  localparam int unsigned BEAT_BYTES = BEAT_W / 8;
  localparam int unsigned LINE_BYTES = LINE_BEATS * BEAT_BYTES;
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(LINE_BYTES - 1);

  type_imem_arb_state_e state_q, state_d;
  type_imem_arb_grant_e last_grant_q, last_grant_d;
  logic                 req_q, req_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [BEAT_W-1:0]    ptw_rdata_q;

  logic ic_elig, ptw_elig, grant_ic;
  logic clr, beat_we, commit, last_beat;
  logic ic_ack_c, ptw_ack_c;

  assign ic_elig  = ic_req_i & ~ic_kill_i;
  assign ptw_elig = ptw_req_i;
  assign grant_ic = ic_elig & (~ptw_elig | (last_grant_q == ARB_GRANT_PTW));

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    req_d        = req_q;
    addr_d       = addr_q;
    clr          = 1'b0;
    beat_we      = 1'b0;
    commit       = 1'b0;
    ic_ack_c     = 1'b0;
    ptw_ack_c    = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (grant_ic) begin
          addr_d       = ic_addr_i & LINE_MASK;
          last_grant_d = ARB_GRANT_IC;
          clr          = 1'b1;
          req_d        = 1'b1;
          state_d      = ARB_IC_BUSY;
        end else if (ptw_elig) begin
          addr_d       = ptw_addr_i;
          last_grant_d = ARB_GRANT_PTW;
          clr          = 1'b1;
          req_d        = 1'b1;
          state_d      = ARB_PTW_BUSY;
        end
      end
      ARB_IC_BUSY: begin
        if (mem_ack_i) begin
          beat_we = 1'b1;
          addr_d  = addr_q + ADDR_W'(BEAT_BYTES);
        end
        // A kill wins over a coincident final beat; the line is discarded.
        if (ic_kill_i) begin
          state_d = ARB_DRAIN;
          if (mem_ack_i) begin
            req_d = 1'b0;
          end
        end else if (mem_ack_i && last_beat) begin
          commit   = 1'b1;
          ic_ack_c = 1'b1;
          req_d    = 1'b0;
          state_d  = ARB_IDLE;
        end
      end
      ARB_PTW_BUSY: begin
        if (mem_ack_i) begin
          ptw_ack_c = 1'b1;
          req_d     = 1'b0;
          state_d   = ARB_IDLE;
        end
      end
      ARB_DRAIN: begin
        if (!req_q || mem_ack_i) begin
          req_d   = 1'b0;
          state_d = ARB_IDLE;
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ARB_IDLE;
      last_grant_q <= ARB_GRANT_IC;
      req_q        <= 1'b0;
      addr_q       <= '0;
      ptw_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      req_q        <= req_d;
      addr_q       <= addr_d;
      if (ptw_ack_c) begin
        ptw_rdata_q <= mem_rdata_i;
      end
    end
  end

  imem_line_assembler #(
    .BEAT_W     (BEAT_W),
    .LINE_BEATS (LINE_BEATS)
  ) u_line_asm (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr_i       (clr),
    .beat_we_i   (beat_we),
    .commit_i    (commit & rst_n),
    .rdata_i     (mem_rdata_i),
    .last_beat_o (last_beat),
    .line_o      (ic_line_o)
  );

  // Acks are suppressed while reset is held so in-flight data is dropped.
  assign ic_ack_o    = ic_ack_c & rst_n;
  assign ptw_ack_o   = ptw_ack_c & rst_n;
  assign ptw_rdata_o = ptw_ack_o ? mem_rdata_i : ptw_rdata_q;
  assign mem_req_o   = req_q;
  assign mem_addr_o  = addr_q;

  a_ic_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == ARB_IC_BUSY) |-> (ic_req_i || ic_kill_i));

  a_ptw_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == ARB_PTW_BUSY) |-> ptw_req_i);

endmodule

// File: doc/imem_arbiter.md
Name: imem_arbiter

Overview:
- Shares the single instruction-side memory port between two requesters: icache line refills (multi-beat) and the instruction-side MMU page-table walker (single beat).
- Sits between the icache/MMU and the external memory bus.
- Round-robin arbitration, beat sequencing and line assembly for refills.
- Handles kill requests from fetch (branch/CSR redirect) without corrupting the bus protocol.

Parameters:
- ADDR_W, 32, physical address width
- BEAT_W, 32, memory bus data width per beat
- LINE_BEATS, 4, beats per icache line (power of 2, >=2)

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- ic_req_i  in  1  icache refill request (level, held until ic_ack_o or kill)
- ic_addr_i  in  ADDR_W  refill line address; low log2(LINE_BEATS*BEAT_W/8) bits ignored
- ic_kill_i  in  1  abort current/pending icache refill
- ic_ack_o  out  1  refill complete, line valid this cycle
- ic_line_o  out  LINE_BEATS*BEAT_W  assembled line, beat 0 in LSBs
- ptw_req_i  in  1  page-table-walk read request (level, held until ptw_ack_o)
- ptw_addr_i  in  ADDR_W  PTE address
- ptw_ack_o  out  1  PTE read complete
- ptw_rdata_o  out  BEAT_W  PTE data
- mem_req_o  out  1  bus read request
- mem_addr_o  out  ADDR_W  bus beat address
- mem_ack_i  in  1  beat accepted and data valid
- mem_rdata_i  in  BEAT_W  beat data

Behaviour:
- Decided interface: reset rst_n, synchronous, active-low; clock clk.
- Reset values: mem_req_o=0, mem_addr_o=0, ic_ack_o=0, ptw_ack_o=0, ic_line_o=0, ptw_rdata_o=0, state=IDLE, last_grant=IC, beat_cnt=0.
- Reset mid-transaction drops mem_req_o next cycle. No ack is generated and in-flight data is discarded.
- States: IDLE, IC_BUSY, PTW_BUSY, DRAIN.
- IDLE, arbitration:
  - Eligible requesters: ic = ic_req_i & ~ic_kill_i; ptw = ptw_req_i.
  - If exactly one is eligible, grant it. If both, grant the one not equal to last_grant (reset value IC, so PTW wins the first tie).
  - On grant: latch address (icache: line-aligned base), set last_grant, beat_cnt=0, go to the BUSY state.
  - mem_req_o rises the cycle after the grant (registered). Minimum request-to-bus latency is 1 cycle.
- IC_BUSY:
  - mem_req_o=1; mem_addr_o = base + beat_cnt*(BEAT_W/8).
  - Each mem_ack_i writes mem_rdata_i into line slot beat_cnt, then beat_cnt++.
  - On ack of beat LINE_BEATS-1: ic_ack_o=1 for that one cycle, combinational with mem_ack_i. ic_line_o holds the full line, including the final beat bypassed from mem_rdata_i. Go to IDLE.
- PTW_BUSY:
  - mem_req_o=1, mem_addr_o = latched PTE address.
  - On mem_ack_i: ptw_ack_o=1 and ptw_rdata_o=mem_rdata_i in the same cycle. Go to IDLE.
- Kill:
  - ic_kill_i in IC_BUSY before the final-beat ack: go to DRAIN.
  - A kill in the same cycle as the final-beat ack also goes to DRAIN, and that ack is suppressed.
  - In DRAIN, mem_req_o stays 1 with the current beat address until the outstanding beat's mem_ack_i is consumed. Then drop mem_req_o and go to IDLE. Remaining beats are not issued.
  - ic_ack_o is never asserted for a killed refill.
  - Kill in IDLE blocks an icache grant that cycle.
  - Kill has no effect on PTW_BUSY.
- Bus rule: once mem_req_o=1, mem_addr_o is stable until mem_ack_i. mem_req_o never drops without an ack.
- Return to IDLE costs one bubble cycle before the next grant. Back-to-back grants are not supported.
- Requesters deasserting req without a kill/ack is illegal and is covered by an assertion.
- Widths: beat_cnt is log2(LINE_BEATS) bits. Address increment wraps within ADDR_W (no overflow flag).
- ic_line_o and ptw_rdata_o hold their last values when no ack is given.

Decomposition:
- Shared package (cache_defs): state enum type_imem_arb_state_e, grant enum type_imem_arb_grant_e {ARB_GRANT_IC, ARB_GRANT_PTW}, derived localparams LINE_W and BEAT_OFFSET_W.
- One natural sub-module: imem_line_assembler (beat counter, slot write, final-beat bypass).
- Arbitration and the FSM stay in the top module.

Test Plan:
- Single refill: ic_req_i, ic_addr_i=0x8000_0014, mem_ack_i every cycle.
  -> mem_addr_o = 0x8000_0010, _14, _18, _1C on successive cycles.
  -> ic_ack_o for 1 cycle on the 4th ack, ic_line_o = {D3,D2,D1,D0}.
- Tie: ic_req_i and ptw_req_i rise together after reset -> PTW granted first, icache second.
  - Repeat the tie: PTW again first (round-robin), since last grant was IC.
- Kill mid-refill: kill after beat 1 ack, mem_ack_i delayed 3 cycles on beat 2.
  -> mem_req_o held with addr base+8 until the ack.
  -> no ic_ack_o; IDLE; beat 3 never issued.
- Kill coincident with final-beat ack -> ic_ack_o stays 0; next ptw_req_i is granted normally.
- PTW with waits: ptw_addr_i=0x8020_0FF8, mem_ack_i after 5 cycles.
  -> mem_addr_o stable for 5 cycles.
  -> ptw_ack_o=1 and ptw_rdata_o=mem_rdata_i in the ack cycle.
- Reset asserted in IC_BUSY after 2 beats -> next cycle mem_req_o=0, all acks 0; a fresh refill afterwards starts at beat 0.
